// File: rtl/mem_access_unit_if.sv
// ============================================================================
// Module      : mem_access_unit_if
// Description : Bundles the three handshakes of the memory access unit:
//               the upstream op port (in_*, flush), the downstream result
//               port (out_*) and the data-memory bus (data_*).
//               slave  = view of the memory access unit itself
//               master = view of the surrounding pipeline / memory
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface mem_access_unit_if #(
    parameter int ADDR_W = 32
);
    // upstream op port
    logic              in_valid;
    logic              in_ready;
    logic              in_mem;
    logic [2:0]        in_lsop;
    logic [31:0]       in_addr;
    logic [31:0]       in_wdata;
    logic [4:0]        in_rw;
    logic              flush;
    // downstream result port
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_rdata;
    logic [4:0]        out_rw;
    logic              out_exc;
    logic [4:0]        out_excode;
    logic [31:0]       out_badvaddr;
    // data-memory bus
    logic              data_req;
    logic              data_wr;
    logic [3:0]        data_wstrb;
    logic [ADDR_W-1:0] data_addr;
    logic [31:0]       data_wdata;
    logic              data_addr_ok;
    logic [31:0]       data_rdata;
    logic              data_data_ok;

    modport slave (
        input  in_valid, in_mem, in_lsop, in_addr, in_wdata, in_rw, flush,
        input  out_ready,
        input  data_addr_ok, data_rdata, data_data_ok,
        output in_ready,
        output out_valid, out_rdata, out_rw, out_exc, out_excode, out_badvaddr,
        output data_req, data_wr, data_wstrb, data_addr, data_wdata
    );

    modport master (
        output in_valid, in_mem, in_lsop, in_addr, in_wdata, in_rw, flush,
        output out_ready,
        output data_addr_ok, data_rdata, data_data_ok,
        input  in_ready,
        input  out_valid, out_rdata, out_rw, out_exc, out_excode, out_badvaddr,
        input  data_req, data_wr, data_wstrb, data_addr, data_wdata
    );
endinterface

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// Module      : mem_access_unit
// Description : Single-outstanding load/store unit. Accepts one op, checks
//               alignment, issues it on the data bus (addr_ok / data_ok
//               split handshake), aligns/extends load data and presents the
//               result with a valid/ready handshake. Supports flush at any
//               stage and asynchronous reset.
//               Optional feature macro: MEM_STORE_BUF_EN - stores complete
//               on address acceptance; one outstanding store data_ok is
//               tracked in the background.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module mem_access_unit #(
    parameter int ADDR_W   = 32,
    parameter int ADDR_CLR = 3
) (
    input  wire logic           clk,
    input  wire logic           rst,
    mem_access_unit_if.slave    bus
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [2:0]  c_OP_LB  = 3'b000;
    localparam logic [2:0]  c_OP_LBU = 3'b001;
    localparam logic [2:0]  c_OP_LH  = 3'b010;
    localparam logic [2:0]  c_OP_LHU = 3'b011;
    localparam logic [2:0]  c_OP_LW  = 3'b100;
    localparam logic [2:0]  c_OP_SB  = 3'b101;
    localparam logic [2:0]  c_OP_SH  = 3'b110;
    localparam logic [2:0]  c_OP_SW  = 3'b111;
    localparam logic [4:0]  c_EXC_ADEL = 5'd4;
    localparam logic [4:0]  c_EXC_ADES = 5'd5;
    // keeps every address bit except the top ADDR_CLR ones
    localparam logic [31:0] c_ADDR_MASK = 32'hFFFF_FFFF >> ADDR_CLR;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_RESP  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    // captured op
    logic [2:0]  r_op;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [4:0]  r_rw;
    logic        r_exc;
    logic [4:0]  r_excode;
    logic [31:0] r_rdata;

    logic        w_in_ready;
    logic        w_accept;
    logic        w_in_store;
    logic        w_in_misalign;
    logic        w_r_store;
    logic        w_load_done;
    logic        w_post_store;
    logic        w_mem_block;
    logic [31:0] w_load_val;
    logic [7:0]  w_lane_b;
    logic [15:0] w_lane_h;
    logic [3:0]  w_strb;
    logic [31:0] w_wdata_rep;
    logic [31:0] w_addr_clr;
    logic [ADDR_W-1:0] w_addr_out;

    // ------------------------------------------------------------------
    // Input decode
    // ------------------------------------------------------------------
    assign w_in_store    = bus.in_lsop[2] & (|bus.in_lsop[1:0]);
    assign w_in_misalign =
        (((bus.in_lsop == c_OP_LH) || (bus.in_lsop == c_OP_LHU) ||
          (bus.in_lsop == c_OP_SH)) && bus.in_addr[0]) ||
        (((bus.in_lsop == c_OP_LW) || (bus.in_lsop == c_OP_SW)) &&
          (|bus.in_addr[1:0]));
    assign w_accept      = bus.in_valid & w_in_ready;
    assign w_r_store     = r_op[2] & (|r_op[1:0]);

    // ------------------------------------------------------------------
    // Optional posted-store tracking
    // ------------------------------------------------------------------
`ifdef MEM_STORE_BUF_EN
    logic r_st_pend;

    // A store that got addr_ok without data_ok leaves one data_ok owed;
    // track it so the next memory op cannot be confused with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_st_pend <= 1'b0;
        end else if ((r_state == S_REQ) && bus.data_addr_ok &&
                     w_r_store && !bus.data_data_ok) begin
            r_st_pend <= 1'b1;
        end else if (bus.data_data_ok) begin
            r_st_pend <= 1'b0;
        end
    end

    assign w_post_store = w_r_store;
    assign w_mem_block  = r_st_pend & bus.in_mem;
`else
    assign w_post_store = 1'b0;
    assign w_mem_block  = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Address: clear the top bits, then fit to the bus width
    // ------------------------------------------------------------------
    assign w_addr_clr = r_addr & c_ADDR_MASK;

    generate
        if (ADDR_W <= 32) begin : g_addr_trunc
            assign w_addr_out = w_addr_clr[ADDR_W-1:0];
        end else begin : g_addr_ext
            assign w_addr_out = {{(ADDR_W-32){1'b0}}, w_addr_clr};
        end
    endgenerate

    // Store lane strobes and write-data replication
    always_comb begin
        w_strb      = 4'b0000;
        w_wdata_rep = 32'd0;
        case (r_op)
            c_OP_SB: begin
                w_strb      = 4'b0001 << r_addr[1:0];
                w_wdata_rep = {4{r_wdata[7:0]}};
            end
            c_OP_SH: begin
                w_strb      = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata_rep = {2{r_wdata[15:0]}};
            end
            c_OP_SW: begin
                w_strb      = 4'b1111;
                w_wdata_rep = r_wdata;
            end
            default: begin
                w_strb      = 4'b0000;
                w_wdata_rep = 32'd0;
            end
        endcase
    end

    // Load lane select and sign/zero extension
    always_comb begin
        w_lane_b   = 8'd0;
        w_lane_h   = r_addr[1] ? bus.data_rdata[31:16] : bus.data_rdata[15:0];
        w_load_val = 32'd0;
        case (r_addr[1:0])
            2'd0:    w_lane_b = bus.data_rdata[7:0];
            2'd1:    w_lane_b = bus.data_rdata[15:8];
            2'd2:    w_lane_b = bus.data_rdata[23:16];
            default: w_lane_b = bus.data_rdata[31:24];
        endcase
        case (r_op)
            c_OP_LB:  w_load_val = {{24{w_lane_b[7]}}, w_lane_b};
            c_OP_LBU: w_load_val = {24'd0, w_lane_b};
            c_OP_LH:  w_load_val = {{16{w_lane_h[15]}}, w_lane_h};
            c_OP_LHU: w_load_val = {16'd0, w_lane_h};
            c_OP_LW:  w_load_val = bus.data_rdata;
            default:  w_load_val = 32'd0;
        endcase
    end

    // load data arrives either together with addr_ok or later in WAIT
    assign w_load_done = !w_r_store && bus.data_data_ok &&
                         (((r_state == S_REQ) && bus.data_addr_ok) ||
                          (r_state == S_WAIT));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // FSM state register, asynchronously cleared to IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture the op on acceptance and the aligned load data on data_ok
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= 3'd0;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_rw     <= 5'd0;
            r_exc    <= 1'b0;
            r_excode <= 5'd0;
            r_rdata  <= 32'd0;
        end else if (w_accept) begin
            r_op     <= bus.in_lsop;
            r_addr   <= bus.in_addr;
            r_wdata  <= bus.in_wdata;
            r_rw     <= bus.in_rw;
            r_exc    <= bus.in_mem & w_in_misalign;
            r_excode <= (bus.in_mem & w_in_misalign) ?
                        (w_in_store ? c_EXC_ADES : c_EXC_ADEL) : 5'd0;
            r_rdata  <= 32'd0;
        end else if (w_load_done) begin
            r_rdata  <= w_load_val;
        end
    end

    // Next-state and handshake/bus outputs
    always_comb begin
        w_state_nxt      = r_state;
        w_in_ready       = 1'b0;
        bus.data_req     = 1'b0;
        bus.data_wr      = 1'b0;
        bus.data_wstrb   = 4'b0000;
        bus.data_addr    = '0;
        bus.data_wdata   = 32'd0;
        bus.out_valid    = 1'b0;
        bus.out_rdata    = 32'd0;
        bus.out_rw       = 5'd0;
        bus.out_exc      = 1'b0;
        bus.out_excode   = 5'd0;
        bus.out_badvaddr = 32'd0;

        case (r_state)
            S_IDLE: begin
                w_in_ready = !rst && !w_mem_block;
                if (w_accept) begin
                    w_state_nxt = (bus.in_mem && !w_in_misalign) ? S_REQ : S_RESP;
                end
            end
            S_REQ: begin
                bus.data_req   = 1'b1;
                bus.data_wr    = w_r_store;
                bus.data_wstrb = w_strb;
                bus.data_addr  = w_addr_out;
                bus.data_wdata = w_wdata_rep;
                if (bus.data_addr_ok) begin
                    if (bus.data_data_ok || w_post_store) begin
                        w_state_nxt = bus.flush ? S_IDLE : S_RESP;
                    end else begin
                        w_state_nxt = bus.flush ? S_DRAIN : S_WAIT;
                    end
                end else if (bus.flush) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                if (bus.data_data_ok) begin
                    w_state_nxt = bus.flush ? S_IDLE : S_RESP;
                end else if (bus.flush) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_RESP: begin
                bus.out_valid    = 1'b1;
                bus.out_rdata    = r_rdata;
                bus.out_rw       = r_rw;
                bus.out_exc      = r_exc;
                bus.out_excode   = r_excode;
                bus.out_badvaddr = r_exc ? r_addr : 32'd0;
                if (bus.flush || bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (bus.data_data_ok) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.in_ready = w_in_ready;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Directed self-checking bench for mem_access_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mem_access_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    mem_access_unit_if #(.ADDR_W(32)) bus ();

    mem_access_unit #(
        .ADDR_W   (32),
        .ADDR_CLR (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // present one op for a single cycle; returns just after the accept edge
    task automatic issue(input logic [2:0] op, input logic mem, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rw);
        bus.in_valid = 1'b1;
        bus.in_mem   = mem;
        bus.in_lsop  = op;
        bus.in_addr  = addr;
        bus.in_wdata = wdata;
        bus.in_rw    = rw;
        #1;
        check("in_ready_pre", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic finish_resp();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    // zero-wait load: addr_ok and data_ok together in the REQ cycle
    task automatic load_zw(input string tag, input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp);
        issue(op, 1'b1, addr, 32'd0, 5'd3);
        bus.data_addr_ok = 1'b1;
        bus.data_data_ok = 1'b1;
        bus.data_rdata   = rdata;
        tick();
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b0;
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_rdata"}, bus.out_rdata, exp);
        finish_resp();
    endtask

    // zero-wait store with bus-side checks in the REQ cycle
    task automatic store_zw(input string tag, input logic [2:0] op, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] strb,
                            input logic [31:0] exp_wdata);
        issue(op, 1'b1, addr, wdata, 5'd4);
        check({tag, "_wr"},    32'(bus.data_wr), 32'd1);
        check({tag, "_wstrb"}, 32'(bus.data_wstrb), 32'(strb));
        check({tag, "_wdata"}, bus.data_wdata, exp_wdata);
        check({tag, "_addr"},  bus.data_addr, addr & 32'h1FFF_FFFF);
        bus.data_addr_ok = 1'b1;
        bus.data_data_ok = 1'b1;
        tick();
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b0;
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_rdata"}, bus.out_rdata, 32'd0);
        finish_resp();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 0; bus.in_mem = 0; bus.in_lsop = 0; bus.in_addr = 0;
        bus.in_wdata = 0; bus.in_rw = 0; bus.flush = 0; bus.out_ready = 0;
        bus.data_addr_ok = 0; bus.data_rdata = 0; bus.data_data_ok = 0;

        // reset state
        #12;
        check("rst_data_req",  32'(bus.data_req), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready",  32'(bus.in_ready), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("idle_in_ready", 32'(bus.in_ready), 32'd1);

        // LB 0x80000003 with one addr_ok wait and one data_ok wait
        issue(3'b000, 1'b1, 32'h8000_0003, 32'd0, 5'd7);
        check("lb_req",   32'(bus.data_req), 32'd1);
        check("lb_wr",    32'(bus.data_wr), 32'd0);
        check("lb_wstrb", 32'(bus.data_wstrb), 32'd0);
        check("lb_addr",  bus.data_addr, 32'h0000_0003);
        check("lb_rdy",   32'(bus.in_ready), 32'd0);
        tick();
        check("lb_req_hold",  32'(bus.data_req), 32'd1);
        check("lb_addr_hold", bus.data_addr, 32'h0000_0003);
        bus.data_addr_ok = 1'b1;
        tick();
        bus.data_addr_ok = 1'b0;
        check("lb_wait_req", 32'(bus.data_req), 32'd0);
        check("lb_wait_ov",  32'(bus.out_valid), 32'd0);
        bus.data_data_ok = 1'b1;
        bus.data_rdata   = 32'h80AA_BBCC;
        tick();
        bus.data_data_ok = 1'b0;
        bus.data_rdata   = 32'h0;
        check("lb_valid", 32'(bus.out_valid), 32'd1);
        check("lb_rdata", bus.out_rdata, 32'hFFFF_FF80);
        check("lb_rw",    32'(bus.out_rw), 32'd7);
        check("lb_exc",   32'(bus.out_exc), 32'd0);
        tick();
        check("lb_hold_valid", 32'(bus.out_valid), 32'd1);
        check("lb_hold_rdata", bus.out_rdata, 32'hFFFF_FF80);
        finish_resp();
        check("lb_done_valid", 32'(bus.out_valid), 32'd0);
        check("lb_done_rdy",   32'(bus.in_ready), 32'd1);

        // stores
        store_zw("sh", 3'b110, 32'h0000_1002, 32'h1234_ABCD, 4'b1100, 32'hABCD_ABCD);
        store_zw("sh_lo", 3'b110, 32'h0000_1000, 32'h1234_ABCD, 4'b0011, 32'hABCD_ABCD);
        store_zw("sb", 3'b101, 32'h0000_1001, 32'h0000_00A5, 4'b0010, 32'hA5A5_A5A5);
        store_zw("sw", 3'b111, 32'hE000_0010, 32'h1122_3344, 4'b1111, 32'h1122_3344);

        // misaligned LW: exception, no memory request
        issue(3'b100, 1'b1, 32'h0000_1006, 32'd0, 5'd2);
        check("lwx_req",   32'(bus.data_req), 32'd0);
        check("lwx_valid", 32'(bus.out_valid), 32'd1);
        check("lwx_exc",   32'(bus.out_exc), 32'd1);
        check("lwx_code",  32'(bus.out_excode), 32'd4);
        check("lwx_bad",   bus.out_badvaddr, 32'h0000_1006);
        finish_resp();

        // misaligned SW -> store exception code
        issue(3'b111, 1'b1, 32'h0000_2001, 32'd0, 5'd2);
        check("swx_req",  32'(bus.data_req), 32'd0);
        check("swx_code", 32'(bus.out_excode), 32'd5);
        check("swx_bad",  bus.out_badvaddr, 32'h0000_2001);
        finish_resp();

        // non-memory op passes straight to RESP
        issue(3'b000, 1'b0, 32'h0000_0001, 32'd0, 5'd9);
        check("nm_req",   32'(bus.data_req), 32'd0);
        check("nm_valid", 32'(bus.out_valid), 32'd1);
        check("nm_rw",    32'(bus.out_rw), 32'd9);
        check("nm_exc",   32'(bus.out_exc), 32'd0);
        finish_resp();

        // LHU 0x2, addr_ok+data_ok together (held high even while idle)
        bus.data_addr_ok = 1'b1;
        bus.data_data_ok = 1'b1;
        bus.data_rdata   = 32'h8001_FFFF;
        issue(3'b011, 1'b1, 32'h0000_0002, 32'd0, 5'd5);
        check("lhu_c1_valid", 32'(bus.out_valid), 32'd0);
        check("lhu_c1_req",   32'(bus.data_req), 32'd1);
        tick();
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b0;
        check("lhu_c2_valid", 32'(bus.out_valid), 32'd1);
        check("lhu_rdata",    bus.out_rdata, 32'h0000_8001);
        finish_resp();

        // other load extensions
        load_zw("lh",  3'b010, 32'h0000_0000, 32'h0001_8000, 32'hFFFF_8000);
        load_zw("lbu", 3'b001, 32'h0000_0001, 32'h0000_F000, 32'h0000_00F0);
        load_zw("lw",  3'b100, 32'h0000_0010, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

        // flush in WAIT, data_ok three cycles later
        issue(3'b100, 1'b1, 32'h0000_0100, 32'd0, 5'd1);
        bus.data_addr_ok = 1'b1;
        tick();
        bus.data_addr_ok = 1'b0;
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("fw_d1_valid", 32'(bus.out_valid), 32'd0);
        check("fw_d1_rdy",   32'(bus.in_ready), 32'd0);
        tick();
        check("fw_d2_rdy",   32'(bus.in_ready), 32'd0);
        bus.data_data_ok = 1'b1;
        tick();
        bus.data_data_ok = 1'b0;
        check("fw_end_rdy",   32'(bus.in_ready), 32'd1);
        check("fw_end_valid", 32'(bus.out_valid), 32'd0);

        // flush in REQ before addr_ok
        issue(3'b000, 1'b1, 32'h0000_0200, 32'd0, 5'd1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("fr_req",   32'(bus.data_req), 32'd0);
        check("fr_valid", 32'(bus.out_valid), 32'd0);
        check("fr_rdy",   32'(bus.in_ready), 32'd1);

        // flush in RESP drops out_valid
        issue(3'b000, 1'b0, 32'h0, 32'd0, 5'd1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("fresp_valid", 32'(bus.out_valid), 32'd0);
        check("fresp_rdy",   32'(bus.in_ready), 32'd1);

        // asynchronous reset in REQ
        issue(3'b100, 1'b1, 32'h0000_0300, 32'd0, 5'd1);
        check("rr_req_before", 32'(bus.data_req), 32'd1);
        rst = 1'b1;
        #1;
        check("rr_req_async", 32'(bus.data_req), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("rr_rdy",   32'(bus.in_ready), 32'd1);
        check("rr_valid", 32'(bus.out_valid), 32'd0);
        check("rr_req",   32'(bus.data_req), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
